// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for ALU_System.
// A timing counter walks RST -> F0 -> F1 -> E0 (-> E1) and the full
// ALU_System control word is decoded from that state and the instruction
// register. Together with ALU_System this forms a self-running CPU.
module control_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [2:0]  SeqCounter
);

    // Codes 5 and 6 are deliberately unnamed; they fall into the default arm.
    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_F0   = 3'd1,
        ST_F1   = 3'd2,
        ST_E0   = 3'd3,
        ST_E1   = 3'd4,
        ST_HALT = 3'd7
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h0;
    localparam logic [3:0] OP_LDM = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_BRA = 4'h6;
    localparam logic [3:0] OP_BEQ = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Register function codes shared by RF, ARF and IR.
    localparam logic [1:0] FUN_INC   = 2'b01;
    localparam logic [1:0] FUN_LOAD  = 2'b10;
    localparam logic [1:0] FUN_CLEAR = 2'b11;

    // Mux source codes shared by MuxA and MuxB.
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_IMM = 2'b10;

    state_t      state;
    logic [3:0]  opcode;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [3:0]  rd_onehot;
    logic        z_flag;
    logic        unused_bits;

    assign opcode      = IROut[15:12];
    assign rd          = IROut[11:10];
    assign rs          = IROut[9:8];
    assign rd_onehot   = 4'b1000 >> rd;
    assign z_flag      = ALUOutFlag[3];
    // Immediate and C/N/O flags travel through the datapath, not this block.
    assign unused_bits = ^{IROut[7:0], ALUOutFlag[2:0]};
    assign SeqCounter  = state;

    // Timing counter: fetch two bytes, execute one or two cycles, or halt.
    // NOTE: state updates use <= so every flop samples the pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_RST;
        end else begin
            case (state)
                ST_RST:  state <= ST_F0;
                ST_F0:   state <= ST_F1;
                ST_F1:   state <= ST_E0;
                ST_E0: begin
                    if (opcode == OP_LDM || opcode == OP_ST) state <= ST_E1;
                    else if (opcode == OP_HLT)               state <= ST_HALT;
                    else                                     state <= ST_F0;
                end
                ST_E1:   state <= ST_F0;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RST;
            endcase
        end
    end

    // Control word decode from the current state and instruction.
    // NOTE: every output gets its idle value first, so no path can infer a latch.
    always_comb begin
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = 2'b00;
        RF_RSel     = 4'b0000;
        RF_TSel     = 4'b0000;
        ALU_FunSel  = 4'b0000;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 2'b00;
        ARF_RegSel  = 4'b0000;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = 2'b00;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;

        case (state)
            ST_RST: begin
                ARF_FunSel = FUN_CLEAR;
                ARF_RegSel = 4'b1000;
            end
            ST_F0, ST_F1: begin
                // Combinational memory lets the IR byte and PC+1 land on one edge.
                ARF_OutDSel = 2'b00;
                Mem_CS      = 1'b0;
                IR_Enable   = 1'b1;
                IR_LH       = (state == ST_F1);
                IR_Funsel   = FUN_LOAD;
                ARF_FunSel  = FUN_INC;
                ARF_RegSel  = 4'b1000;
            end
            ST_E0: begin
                case (opcode)
                    OP_LDI: begin
                        MuxASel   = SRC_IMM;
                        RF_FunSel = FUN_LOAD;
                        RF_RSel   = rd_onehot;
                    end
                    OP_LDM, OP_ST: begin
                        MuxBSel    = SRC_IMM;
                        ARF_FunSel = FUN_LOAD;
                        ARF_RegSel = 4'b0100;
                    end
                    OP_ADD, OP_AND: begin
                        RF_OutASel = {1'b0, rd};
                        RF_OutBSel = {1'b0, rs};
                        ALU_FunSel = (opcode == OP_ADD) ? 4'b0100 : 4'b0111;
                        RF_FunSel  = FUN_LOAD;
                        RF_RSel    = rd_onehot;
                    end
                    OP_NOT: begin
                        RF_OutBSel = {1'b0, rs};
                        ALU_FunSel = 4'b0011;
                        RF_FunSel  = FUN_LOAD;
                        RF_RSel    = rd_onehot;
                    end
                    OP_BRA, OP_BEQ: begin
                        if (opcode == OP_BRA || z_flag) begin
                            MuxBSel    = SRC_IMM;
                            ARF_FunSel = FUN_LOAD;
                            ARF_RegSel = 4'b1000;
                        end
                    end
                    default: ;
                endcase
            end
            ST_E1: begin
                if (opcode == OP_LDM) begin
                    ARF_OutDSel = 2'b10;
                    Mem_CS      = 1'b0;
                    MuxASel     = SRC_MEM;
                    RF_FunSel   = FUN_LOAD;
                    RF_RSel     = rd_onehot;
                end else if (opcode == OP_ST) begin
                    RF_OutASel  = {1'b0, rd};
                    ARF_OutDSel = 2'b10;
                    Mem_CS      = 1'b0;
                    Mem_WR      = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
